// File: rtl/instr_word_encoder.sv
// instr_word_encoder: packs mnemonic + fields into MIPS words and streams them
// with byte addresses through a small valid/ready output FIFO.
module instr_word_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err_pulse,
  output logic [7:0]  err_count
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic [31:0] r_addr;
  logic r_end_pending, r_done, r_err_pulse;
  logic [7:0] r_err_count;

  logic [31:0] w_word;
  logic [5:0] w_funct, w_opcode;
  logic w_rtype, w_sll, w_end, w_illegal, w_accept, w_push, w_pop;

  assign w_rtype   = ~in_op[3];
  assign w_sll     = in_op == 4'd6;
  assign w_end     = in_op == 4'd13;
  assign w_illegal = in_op >= 4'd14;

  always_comb begin
    w_funct  = 6'b100000;
    w_opcode = 6'b000000;
    case (in_op)
      4'd1:    w_funct  = 6'b100001;
      4'd2:    w_funct  = 6'b100010;
      4'd3:    w_funct  = 6'b100100;
      4'd4:    w_funct  = 6'b100101;
      4'd5:    w_funct  = 6'b100111;
      4'd6:    w_funct  = 6'b000000;
      4'd7:    w_funct  = 6'b000111;
      4'd8:    w_opcode = 6'b001000;
      4'd9:    w_opcode = 6'b100011;
      4'd10:   w_opcode = 6'b101011;
      4'd11:   w_opcode = 6'b000100;
      4'd12:   w_opcode = 6'b000101;
      default: w_opcode = 6'b000000;
    endcase
    w_word = w_rtype ? {6'b0, w_sll ? 5'd0 : in_rs, in_rt, in_rd, w_sll ? in_shamt : 5'd0, w_funct}
           : w_end   ? END_WORD
           : {w_opcode, in_rs, in_rt, in_imm};
  end

  // No bypass: a full FIFO refuses input even when the head is popped this cycle
  assign in_ready  = (r_count < DEPTH) & ~r_done & ~r_end_pending;
  assign w_accept  = in_valid & in_ready;
  assign w_push    = w_accept & ~w_illegal;
  assign w_pop     = out_valid & out_ready;
  assign out_valid = r_count != '0;
  assign out_word  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_addr  = r_addr;
  assign done      = r_done;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr_ptr] <= w_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_addr        <= BASE_ADDR;
      r_end_pending <= 1'b0;
      r_done        <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_count   <= 8'd0;
    end else begin
      r_wr_ptr      <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr      <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count       <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_addr        <= w_pop ? r_addr + 32'd4 : r_addr;
      r_end_pending <= r_end_pending | (w_push & w_end);
      // Legal encodings never use opcode 111111, so all-ones identifies END
      r_done        <= r_done | (w_pop & (out_word == END_WORD));
      r_err_pulse   <= w_accept & w_illegal;
      r_err_count   <= (w_accept & w_illegal & (r_err_count != 8'hFF)) ? r_err_count + 8'd1 : r_err_count;
    end
  end
endmodule

// File: tb/tb_instr_word_encoder.sv
// tb_instr_word_encoder: directed vectors with hand-computed MIPS words.
module tb_instr_word_encoder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word, out_addr;
  logic        done, err_pulse;
  logic [7:0]  err_count;
  int n_cmp = 0;
  int n_fail = 0;

  instr_word_encoder dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .done(done), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clock = ~clock;

  logic [3:0]  t_op   [9] = '{4'd6, 4'd5, 4'd2, 4'd3, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11};
  logic [4:0]  t_rs   [9] = '{5'd4, 5'd7, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd29, 5'd3};
  logic [4:0]  t_rt   [9] = '{5'd3, 5'd12, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd8, 5'd0};
  logic [4:0]  t_rd   [9] = '{5'd3, 5'd5, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd31, 5'd7};
  logic [4:0]  t_sh   [9] = '{5'd1, 5'd9, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd2};
  logic [15:0] t_imm  [9] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFC, 16'hFFFE};
  logic [31:0] t_word [9] = '{32'h0003_1840, 32'h00EC_2827, 32'h0022_1822, 32'h0022_1824,
                              32'h0022_1825, 32'h0022_1821, 32'h0022_1807, 32'hAFA8_FFFC, 32'h1060_FFFE};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm);
    drive(op, rs, rt, rd, sh, imm);
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clock); #1;
    end
    if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; #2; reset = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_word", out_word, 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_errp", {31'b0, err_pulse}, 32'd0);
    chk("rst_errc", {24'b0, err_count}, 32'd0);
    repeat (2) @(posedge clock);
    #1; reset = 1'b0;

    out_ready = 1'b1;
    send(4'd0, 5'd1, 5'd10, 5'd6, 5'd0, 16'h0);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_word", out_word, 32'h002A_3020);
    chk("add_addr", out_addr, 32'h0);
    @(posedge clock); #1;
    chk("add_popped", {31'b0, out_valid}, 32'd0);
    chk("add_next_addr", out_addr, 32'h4);

    reset_dut();
    send(4'd8, 5'd15, 5'd14, 5'd0, 5'd0, 16'h0002);
    chk("addi_word", out_word, 32'h21EE_0002);
    chk("addi_addr", out_addr, 32'h0);
    send(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0011);
    chk("bne_word", out_word, 32'h1422_0011);
    chk("bne_addr", out_addr, 32'h4);
    send(4'd9, 5'd2, 5'd6, 5'd0, 5'd0, 16'h0108);
    chk("lw_word", out_word, 32'h8C46_0108);
    chk("lw_addr", out_addr, 32'h8);

    reset_dut();
    for (int i = 0; i < 9; i++) begin
      send(t_op[i], t_rs[i], t_rt[i], t_rd[i], t_sh[i], t_imm[i]);
      chk($sformatf("tbl_word%0d", i), out_word, t_word[i]);
      chk($sformatf("tbl_addr%0d", i), out_addr, 32'(i * 4));
    end

    reset_dut();
    out_ready = 1'b0;
    send(4'd0, 5'd1, 5'd10, 5'd6, 5'd0, 16'h0);
    send(4'd8, 5'd15, 5'd14, 5'd0, 5'd0, 16'h0002);
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    drive(4'd9, 5'd2, 5'd6, 5'd0, 5'd0, 16'h0108);
    repeat (3) begin
      @(posedge clock); #1;
      chk("hold_word", out_word, 32'h002A_3020);
      chk("hold_addr", out_addr, 32'h0);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("rel_word1", out_word, 32'h21EE_0002);
    chk("rel_addr1", out_addr, 32'h4);
    chk("rel_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("rel_word2", out_word, 32'h8C46_0108);
    chk("rel_addr2", out_addr, 32'h8);
    @(posedge clock); #1;
    chk("rel_empty", {31'b0, out_valid}, 32'd0);
    chk("rel_addr3", out_addr, 32'hC);

    reset_dut();
    for (int i = 0; i < 3; i++) begin
      send(4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
      chk($sformatf("ill_pulse%0d", i), {31'b0, err_pulse}, 32'd1);
      chk($sformatf("ill_count%0d", i), {24'b0, err_count}, 32'(i + 1));
      chk($sformatf("ill_valid%0d", i), {31'b0, out_valid}, 32'd0);
    end
    @(posedge clock); #1;
    chk("ill_pulse_end", {31'b0, err_pulse}, 32'd0);
    chk("ill_count_end", {24'b0, err_count}, 32'd3);
    send(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    chk("end_word", out_word, 32'hFFFF_FFFF);
    chk("end_addr", out_addr, 32'h0);
    chk("end_ready", {31'b0, in_ready}, 32'd0);
    chk("end_done0", {31'b0, done}, 32'd0);
    @(posedge clock); #1;
    chk("end_done1", {31'b0, done}, 32'd1);
    chk("end_valid", {31'b0, out_valid}, 32'd0);
    chk("end_addr_after", out_addr, 32'h4);
    drive(4'd0, 5'd1, 5'd10, 5'd6, 5'd0, 16'h0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("post_end_ready", {31'b0, in_ready}, 32'd0);
      chk("post_end_valid", {31'b0, out_valid}, 32'd0);
      chk("post_end_done", {31'b0, done}, 32'd1);
    end
    in_valid = 1'b0;

    reset_dut();
    drive(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    repeat (260) @(posedge clock);
    #1;
    chk("sat_count", {24'b0, err_count}, 32'd255);
    chk("sat_pulse", {31'b0, err_pulse}, 32'd1);
    in_valid = 1'b0;

    reset_dut();
    out_ready = 1'b0;
    send(4'd0, 5'd1, 5'd10, 5'd6, 5'd0, 16'h0);
    send(4'd8, 5'd15, 5'd14, 5'd0, 5'd0, 16'h0002);
    chk("mid_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_addr", out_addr, 32'h0);
    chk("mid_rst_word", out_word, 32'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    send(4'd0, 5'd1, 5'd10, 5'd6, 5'd0, 16'h0);
    chk("mid_add_word", out_word, 32'h002A_3020);
    chk("mid_add_addr", out_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
